// File: rtl/jtag_axi_arb_if.sv
// AXI4 single-beat master bus between jtag_axi_arb and the interconnect.
// Signal names keep the arbiter-side _o/_i direction suffixes.
interface jtag_axi_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid_o;
  logic                    awready_i;
  logic [ADDR_WIDTH-1:0]   awaddr_o;
  logic [7:0]              awid_o;
  logic [7:0]              awlen_o;
  logic [2:0]              awsize_o;
  logic [1:0]              awburst_o;
  logic                    wvalid_o;
  logic                    wready_i;
  logic [DATA_WIDTH-1:0]   wdata_o;
  logic [DATA_WIDTH/8-1:0] wstrb_o;
  logic                    wlast_o;
  logic                    bvalid_i;
  logic                    bready_o;
  logic [1:0]              bresp_i;
  logic                    arvalid_o;
  logic                    arready_i;
  logic [ADDR_WIDTH-1:0]   araddr_o;
  logic [7:0]              arid_o;
  logic [7:0]              arlen_o;
  logic [2:0]              arsize_o;
  logic [1:0]              arburst_o;
  logic                    rvalid_i;
  logic                    rready_o;
  logic [DATA_WIDTH-1:0]   rdata_i;
  logic [1:0]              rresp_i;

  modport master (
    output awvalid_o, awaddr_o, awid_o, awlen_o, awsize_o, awburst_o,
    output wvalid_o, wdata_o, wstrb_o, wlast_o, bready_o,
    output arvalid_o, araddr_o, arid_o, arlen_o, arsize_o, arburst_o, rready_o,
    input  awready_i, wready_i, bvalid_i, bresp_i, arready_i, rvalid_i, rdata_i, rresp_i
  );

  modport slave (
    input  awvalid_o, awaddr_o, awid_o, awlen_o, awsize_o, awburst_o,
    input  wvalid_o, wdata_o, wstrb_o, wlast_o, bready_o,
    input  arvalid_o, araddr_o, arid_o, arlen_o, arsize_o, arburst_o, rready_o,
    output awready_i, wready_i, bvalid_i, bresp_i, arready_i, rvalid_i, rdata_i, rresp_i
  );
endinterface

// File: rtl/jtag_axi_arb.sv
// Round-robin sequencer sharing one AXI4 master port (single outstanding beat) among NUM_REQ requesters.
// Optional response watchdog: define JTAG_AXI_ARB_TIMEOUT_EN.
module jtag_axi_arb #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_MASTER_ID  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk_axi,
  input  logic                              ares_axi,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0]                req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb_i,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  input  logic [NUM_REQ-1:0]                resp_ready_i,
  output logic [DATA_WIDTH-1:0]             resp_rdata_o,
  output logic [1:0]                        resp_err_o,
  jtag_axi_arb_if.master                    axi
);
  localparam int          IW = $clog2(NUM_REQ);
  localparam int          SW = DATA_WIDTH / 8;
  localparam int unsigned NR = NUM_REQ;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_WIDTH != 32 && DATA_WIDTH != 64) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("jtag_axi_arb: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, ADDR_W, ADDR_R, RESP, RET} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d, gnt_q, gnt_d, pick;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]            err_q, err_d;
  logic                  any_req, grant, arb_block, tmo_hit, late_rsp;
  logic                  awvalid, wvalid, arvalid, bready, rready;
  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;

  // First valid requester strictly after the last winner, wrapping.
  always_comb begin
    pick    = rr_q;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= NR; i++) begin
      if (!any_req && req_valid_i[(32'(rr_q) + i) % NR]) begin
        any_req = 1'b1;
        pick    = IW'((32'(rr_q) + i) % NR);
      end
    end
  end

`ifdef JTAG_AXI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          late_q, late_d;

  assign arb_block = late_q;
  assign late_rsp  = late_q;
  assign tmo_hit   = (state_q == RESP) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // The late B/R of a timed-out beat is drained before anything else is issued.
  always_comb begin
    cnt_d  = '0;
    late_d = late_q;
    if (state_q == RESP && state_d == RESP) cnt_d = cnt_q + 1'b1;
    if (tmo_hit && state_d == RET) late_d = 1'b1;
    if (late_q && (b_hs || r_hs)) late_d = 1'b0;
  end

  always_ff @(posedge clk_axi or negedge ares_axi) begin
    if (!ares_axi) begin
      cnt_q  <= '0;
      late_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      late_q <= late_d;
    end
  end
`else
  assign arb_block = 1'b0;
  assign late_rsp  = 1'b0;
  assign tmo_hit   = 1'b0;
`endif

  assign awvalid = (state_q == ADDR_W) && !aw_done_q;
  assign wvalid  = (state_q == ADDR_W) && !w_done_q;
  assign arvalid = (state_q == ADDR_R);
  assign bready  = write_q  && ((state_q == RESP) || late_rsp);
  assign rready  = !write_q && ((state_q == RESP) || late_rsp);
  assign aw_hs   = awvalid & axi.awready_i;
  assign w_hs    = wvalid  & axi.wready_i;
  assign ar_hs   = arvalid & axi.arready_i;
  assign b_hs    = bready  & axi.bvalid_i;
  assign r_hs    = rready  & axi.rvalid_i;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    grant     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req && !arb_block) begin
          grant     = 1'b1;
          gnt_d     = pick;
          rr_d      = pick;
          write_d   = req_write_i[pick];
          addr_d    = req_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d   = req_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d   = req_wstrb_i[pick*SW +: SW];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write_i[pick] ? ADDR_W : ADDR_R;
        end
      end
      ADDR_W: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = RESP;
      end
      ADDR_R: begin
        if (ar_hs) state_d = RESP;
      end
      RESP: begin
        if (b_hs) begin
          err_d   = axi.bresp_i;
          rdata_d = '0;
          state_d = RET;
        end else if (r_hs) begin
          err_d   = axi.rresp_i;
          rdata_d = axi.rdata_i;
          state_d = RET;
        end else if (tmo_hit) begin
          err_d   = 2'b11;
          rdata_d = '0;
          state_d = RET;
        end
      end
      RET: begin
        if (resp_ready_i[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or negedge ares_axi) begin
    if (!ares_axi) begin
      state_q   <= IDLE;
      rr_q      <= IW'(NUM_REQ - 1);
      gnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o  = grant ? (NUM_REQ'(1) << pick) : '0;
  assign resp_valid_o = (state_q == RET) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  assign axi.awvalid_o = awvalid;
  assign axi.awaddr_o  = addr_q;
  assign axi.awid_o    = 8'(AXI_MASTER_ID);
  assign axi.awlen_o   = '0;
  assign axi.awsize_o  = 3'($clog2(SW));
  assign axi.awburst_o = 2'b01;
  assign axi.wvalid_o  = wvalid;
  assign axi.wdata_o   = wdata_q;
  assign axi.wstrb_o   = wstrb_q;
  assign axi.wlast_o   = wvalid;
  assign axi.bready_o  = bready;
  assign axi.arvalid_o = arvalid;
  assign axi.araddr_o  = addr_q;
  assign axi.arid_o    = 8'(AXI_MASTER_ID);
  assign axi.arlen_o   = '0;
  assign axi.arsize_o  = 3'($clog2(SW));
  assign axi.arburst_o = 2'b01;
  assign axi.rready_o  = rready;
endmodule
